// File: rtl/datapath_pkg.sv
// datapath_pkg: bus/enable bit indices and ALU opcodes shared by the datapath files
package datapath_pkg;
    localparam int IDX_R0      = 0;
    localparam int IDX_HI      = 16;
    localparam int IDX_LO      = 17;
    localparam int IDX_ZHI     = 18;
    localparam int IDX_ZLO     = 19;
    localparam int IDX_PC      = 20;
    localparam int IDX_MDR     = 21;
    localparam int IDX_INPORT  = 22;
    localparam int IDX_IR      = 23;
    localparam int IDX_Z       = 24;
    localparam int IDX_MAR     = 25;
    localparam int IDX_OUTPORT = 26;
    localparam int IDX_Y       = 27;
    localparam int NUM_REGS    = 28;
    localparam int NUM_SRCS    = 23;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_ROR  = 4'd6,
        OP_ROL  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SHRA = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12,
        OP_INC  = 4'd13,
        OP_R14  = 4'd14,
        OP_R15  = 4'd15
    } alu_op_t;
endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU, C = f(A, B); MUL/DIV only built with DATAPATH_MULDIV_EN
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [63:0] c
);
    logic [4:0] sh;
    logic [5:0] sh_inv;
    assign sh     = b[4:0];
    assign sh_inv = 6'd32 - {1'b0, sh};
    // a shift by 32 yields 0, so sh=0 rotates back to A unchanged
    always_comb begin
        c = '0;
        case (op)
            OP_ADD:  c[31:0] = a + b;
            OP_SUB:  c[31:0] = a - b;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  c = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            OP_DIV:  c = (b == '0) ? '0 : {$signed(a) % $signed(b), $signed(a) / $signed(b)};
`endif
            OP_AND:  c[31:0] = a & b;
            OP_OR:   c[31:0] = a | b;
            OP_ROR:  c[31:0] = (a >> sh) | (a << sh_inv);
            OP_ROL:  c[31:0] = (a << sh) | (a >> sh_inv);
            OP_SHL:  c[31:0] = a << sh;
            OP_SHR:  c[31:0] = a >> sh;
            OP_SHRA: c[31:0] = $signed(a) >>> sh;
            OP_NEG:  c[31:0] = -b;
            OP_NOT:  c[31:0] = ~b;
            OP_INC:  c[31:0] = b + 32'd1;
            default: c = '0;
        endcase
    end
endmodule

// File: rtl/datapath.sv
// datapath: single-bus CPU datapath (registers, priority bus mux, Z capture); MUL/DIV via DATAPATH_MULDIV_EN
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      enable,
    input  logic [31:0]      busSelect,
    input  logic [WIDTH-1:0] inPort,
    input  logic [WIDTH-1:0] MDataIn,
    input  logic             MD_Read,
    input  logic [3:0]       Control_Signals,
    output logic [WIDTH-1:0] busMuxOut
);
    logic [WIDTH-1:0]   regs_q [NUM_REGS];
    logic [WIDTH-1:0]   regs_d [NUM_REGS];
    logic [WIDTH-1:0]   src [NUM_SRCS];
    logic [2*WIDTH-1:0] z_q, z_d, alu_c;
    logic               unused_bits;

    assign unused_bits = ^{enable[31:28], enable[IDX_INPORT], enable[IDX_ZLO:IDX_ZHI], busSelect[31:23]};

    datapath_alu u_alu (
        .a  (regs_q[IDX_Y]),
        .b  (busMuxOut),
        .op (alu_op_t'(Control_Signals)),
        .c  (alu_c)
    );

    // iterating downward lets the lowest set select bit win
    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) src[i] = regs_q[i];
        src[IDX_ZHI] = z_q[2*WIDTH-1:WIDTH];
        src[IDX_ZLO] = z_q[WIDTH-1:0];
        busMuxOut = '0;
        for (int i = NUM_SRCS - 1; i >= 0; i--) if (busSelect[i]) busMuxOut = src[i];
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = enable[i] ? busMuxOut : regs_q[i];
        regs_d[IDX_MDR]    = enable[IDX_MDR] ? (MD_Read ? MDataIn : busMuxOut) : regs_q[IDX_MDR];
        regs_d[IDX_INPORT] = inPort;
        regs_d[IDX_ZHI]    = '0;
        regs_d[IDX_ZLO]    = '0;
        regs_d[IDX_Z]      = '0;
        z_d = enable[IDX_Z] ? alu_c : z_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            regs_q <= '{default: '0};
            z_q    <= '0;
        end else begin
            regs_q <= regs_d;
            z_q    <= z_d;
        end
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed vectors with hand-computed results for the datapath top
module tb_datapath;
    logic        clk = 0;
    logic        clr = 1;
    logic [31:0] enable = 0, busSelect = 0, inPort = 0, MDataIn = 0;
    logic        MD_Read = 0;
    logic [3:0]  Control_Signals = 0;
    logic [31:0] busMuxOut;
    int          errors = 0, checks = 0;

    datapath dut (
        .clk(clk), .clr(clr), .enable(enable), .busSelect(busSelect),
        .inPort(inPort), .MDataIn(MDataIn), .MD_Read(MD_Read),
        .Control_Signals(Control_Signals), .busMuxOut(busMuxOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bit_of(input int idx);
        return 32'd1 << idx;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [31:0] en, input logic [31:0] sel);
        enable = en;
        busSelect = sel;
        @(posedge clk);
        #1;
        enable = 0;
        busSelect = 0;
    endtask

    task automatic peek(input string tag, input int idx, input logic [31:0] exp);
        busSelect = bit_of(idx);
        #1;
        check(tag, busMuxOut, exp);
        busSelect = 0;
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        inPort = v;
        tick(0, 0);
        tick(bit_of(idx), bit_of(22));
    endtask

    task automatic alu_run(input logic [3:0] op, input logic [31:0] b);
        inPort = b;
        tick(0, 0);
        Control_Signals = op;
        tick(bit_of(24), bit_of(22));
    endtask

    task automatic alu_check(input string tag, input logic [31:0] y, input logic [3:0] op,
                             input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        load_reg(27, y);
        alu_run(op, b);
        peek({tag, "_lo"}, 19, lo);
        peek({tag, "_hi"}, 18, hi);
    endtask

    initial begin
        #1;
        check("reset_bus_idle", busMuxOut, 32'h0);
        #12 clr = 0;
        @(negedge clk);
        peek("reset_r0", 0, 32'h0);
        peek("reset_zlo", 19, 32'h0);

        MDataIn = 32'h1;
        MD_Read = 1;
        tick(bit_of(21), 0);
        MD_Read = 0;
        peek("mdr_load", 21, 32'h1);
        tick(bit_of(3), bit_of(21));
        peek("r3_from_mdr", 3, 32'h1);

        load_reg(5, 32'h2);
        load_reg(1, 32'h3);
        peek("r5_pre", 5, 32'h2);
        tick(bit_of(27), bit_of(3));
        Control_Signals = 4'd8;
        tick(bit_of(24), bit_of(5));
        peek("shl_z", 19, 32'h4);
        tick(bit_of(1), bit_of(19));
        peek("r1_from_z", 1, 32'h4);

        busSelect = bit_of(5) | bit_of(21);
        #1;
        check("bus_priority", busMuxOut, 32'h2);
        busSelect = 0;

`ifdef DATAPATH_MULDIV_EN
        alu_check("mul", 32'hFFFFFFFE, 4'd2, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        alu_check("div", 32'h7, 4'd3, 32'h2, 32'h1, 32'h3);
        alu_check("div_neg", 32'hFFFFFFF9, 4'd3, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
        alu_check("mul_off", 32'hFFFFFFFE, 4'd2, 32'h3, 32'h0, 32'h0);
        alu_check("add_pre", 32'h7, 4'd0, 32'h5, 32'h0, 32'hC);
        alu_check("div_off", 32'h7, 4'd3, 32'h2, 32'h0, 32'h0);
`endif
        alu_check("add", 32'h7, 4'd0, 32'h5, 32'h0, 32'hC);
        alu_check("div0", 32'h7, 4'd3, 32'h0, 32'h0, 32'h0);
        alu_check("sub", 32'h5, 4'd1, 32'h7, 32'h0, 32'hFFFFFFFE);
        alu_check("and", 32'hF0F0, 4'd4, 32'hFF00, 32'h0, 32'hF000);
        alu_check("or", 32'hF0F0, 4'd5, 32'hFF00, 32'h0, 32'hFFF0);
        alu_check("ror", 32'h1, 4'd6, 32'h1, 32'h0, 32'h80000000);
        alu_check("ror0", 32'h12345678, 4'd6, 32'h0, 32'h0, 32'h12345678);
        alu_check("rol", 32'h80000001, 4'd7, 32'h4, 32'h0, 32'h00000018);
        alu_check("shl_mod", 32'h1, 4'd8, 32'h21, 32'h0, 32'h2);
        alu_check("shr", 32'h80000000, 4'd9, 32'h4, 32'h0, 32'h08000000);
        alu_check("shra", 32'h80000000, 4'd10, 32'h21, 32'h0, 32'hC0000000);
        alu_check("neg", 32'h0, 4'd11, 32'h5, 32'h0, 32'hFFFFFFFB);
        alu_check("not", 32'h0, 4'd12, 32'h5, 32'h0, 32'hFFFFFFFA);
        alu_check("inc", 32'h0, 4'd13, 32'hFFFFFFFF, 32'h0, 32'h0);
        alu_check("op14", 32'h7, 4'd14, 32'h5, 32'h0, 32'h0);

        alu_run(4'd13, 32'h41);
        Control_Signals = 4'd13;
        enable = bit_of(24);
        busSelect = bit_of(19);
        #1;
        check("same_cycle_old", busMuxOut, 32'h42);
        @(posedge clk);
        #1;
        check("same_cycle_new", busMuxOut, 32'h43);
        enable = 0;
        busSelect = 0;

        load_reg(20, 32'hCAFE);
        peek("pc_load", 20, 32'hCAFE);
        @(negedge clk);
        clr = 1;
        #1;
        peek("clr_async_pc", 20, 32'h0);
        peek("clr_async_z", 19, 32'h0);
        inPort = 32'h55;
        tick(bit_of(5), bit_of(22));
        peek("clr_holds_r5", 5, 32'h0);
        clr = 0;
        @(negedge clk);
        peek("after_clr_r1", 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
